mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 4-to-1 mux (`_4x1Mux`) between four single-bit requesters. It grants exactly one requester at a time and drives the mux select lines (`s0`, `s1`) and `enable` so the granted requester's input reaches the mux output. Grants are held while the requester keeps its request asserted, with an optional maximum-hold limit for fairness. It sits directly in front of the mux instance in the datapath.

---
 rtl/mux4_rr_arbiter_pkg.sv | 21 ++
 rtl/mux4_rr_arbiter_if.sv | 15 +
 rtl/mux4_rr_arbiter_rr_pick.sv | 28 ++
 rtl/mux4_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the 4-requester round-robin arbiter in front of _4x1Mux.
// Optional grant-hold timeout is enabled by defining MUX4_ARB_TIMEOUT_EN.
package mux4_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0] idx_t;

  function automatic req_vec_t idx_to_onehot(input idx_t idx);
    return req_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant and mux-control bundle between the requesters and the arbiter.
interface mux4_rr_arbiter_if;
  import mux4_arb_pkg::*;

  req_vec_t req;
  req_vec_t gnt;
  logic     s0;
  logic     s1;
  logic     enable;
  logic     busy;

  modport master (output req, input gnt, s0, s1, enable, busy);
  modport slave  (input req, output gnt, s0, s1, enable, busy);

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first eligible request after i_ptr, wrapping to i_ptr last.
module rr_pick
  import mux4_arb_pkg::*;
(
  input  req_vec_t i_req,
  input  idx_t     i_ptr,
  input  req_vec_t i_excl,
  output logic     o_found,
  output idx_t     o_idx
);

  req_vec_t w_cand;

  assign w_cand = i_req & ~i_excl;

  // Walk from farthest to nearest so the nearest candidate after i_ptr is the last write.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (w_cand[i_ptr + IDX_W'(k)]) begin
        o_found = 1'b1;
        o_idx   = i_ptr + IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving _4x1Mux select/enable; grants held while the holder requests.
// Define MUX4_ARB_TIMEOUT_EN to force rotation after MAX_HOLD busy cycles when others wait.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               reset,
  mux4_rr_arbiter_if.slave   bus
);

  if (MAX_HOLD == 0 || MAX_HOLD > 15) begin : g_bad_max_hold
    $error("mux4_rr_arbiter: MAX_HOLD must be in 1..15");
  end

  state_t   r_state, w_state_nxt;
  req_vec_t r_gnt,   w_gnt_nxt;
  idx_t     r_sel,   w_sel_nxt;
  idx_t     r_ptr,   w_ptr_nxt;
  req_vec_t w_excl;
  logic     w_found;
  idx_t     w_idx;
  logic     w_holder_req;
  logic     w_timeout;
  logic     w_load;

  // During BUSY the holder is excluded so any re-arbitration moves the grant elsewhere.
  assign w_excl       = (r_state == ST_BUSY) ? r_gnt : '0;
  assign w_holder_req = |(bus.req & r_gnt);

`ifdef MUX4_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_hold, w_hold_nxt;
  logic             w_others;

  assign w_others  = |(bus.req & ~r_gnt);
  assign w_timeout = w_others && (r_hold >= CNT_W'(MAX_HOLD - 1));
`else
  assign w_timeout = 1'b0;
`endif

  rr_pick u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .i_excl  (w_excl),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= IDX_W'(N_REQ - 1);
`ifdef MUX4_ARB_TIMEOUT_EN
      r_hold  <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
`ifdef MUX4_ARB_TIMEOUT_EN
      r_hold  <= w_hold_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_load      = 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
    w_hold_nxt  = r_hold;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_found) w_load = 1'b1;
      end
      ST_BUSY: begin
        if (!w_holder_req || w_timeout) begin
          if (w_found) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
          end
        end
`ifdef MUX4_ARB_TIMEOUT_EN
        else if (r_hold < CNT_W'(MAX_HOLD)) begin
          w_hold_nxt = r_hold + CNT_W'(1);
        end
`endif
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
    if (w_load) begin
      w_state_nxt = ST_BUSY;
      w_gnt_nxt   = idx_to_onehot(w_idx);
      w_sel_nxt   = w_idx;
      w_ptr_nxt   = w_idx;
`ifdef MUX4_ARB_TIMEOUT_EN
      w_hold_nxt  = '0;
`endif
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.s0     = r_sel[0];
  assign bus.s1     = r_sel[1];
  assign bus.enable = (r_state == ST_BUSY);
  assign bus.busy   = (r_state == ST_BUSY);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus random requests vs a queue-free model.
module tb_mux4_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: holder index (-1 = none), last-granted pointer, cycles held.
  int         m_hold = -1;
  int         m_ptr  = 3;
  int         m_cnt  = 0;
  logic [1:0] m_sel  = 2'b00;

  function automatic int pick(input logic [3:0] r, input int p, input int excl);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (p + k) % 4;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin : model_step
    int w;
    logic [3:0] r;
    if (reset) begin
      m_hold <= -1;
      m_ptr  <= 3;
      m_cnt  <= 0;
      m_sel  <= 2'b00;
    end else begin
      r = bus.req;
      if (m_hold < 0) begin
        w = pick(r, m_ptr, -1);
      end else if (!r[m_hold]) begin
        w = pick(r, m_hold, m_hold);
      end else begin
        w = m_hold;
`ifdef MUX4_ARB_TIMEOUT_EN
        if (m_cnt >= MAX_HOLD - 1 && pick(r, m_hold, m_hold) >= 0) w = pick(r, m_hold, m_hold);
`endif
      end
      if (w < 0) begin
        m_hold <= -1;
      end else if (w != m_hold) begin
        m_hold <= w;
        m_ptr  <= w;
        m_cnt  <= 0;
        m_sel  <= 2'(w);
      end else begin
        m_cnt <= (m_cnt < MAX_HOLD) ? m_cnt + 1 : MAX_HOLD;
      end
    end
  end

  // Every cycle out of reset the DUT outputs must match the model.
  always @(negedge clk) begin
    logic [3:0] eg;
    if (!reset) begin
      eg = (m_hold < 0) ? 4'b0000 : (4'b0001 << m_hold);
      check("model_gnt", bus.gnt, eg);
      check("model_sel", {2'b00, bus.s1, bus.s0}, {2'b00, m_sel});
      check("model_enable", {3'b000, bus.enable}, {3'b000, m_hold >= 0});
      check("model_busy", {3'b000, bus.busy}, {3'b000, m_hold >= 0});
    end
  end

  task automatic pulse_reset();
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] exp;
    bus.req = 4'b0000;
    #1 reset = 1'b1;
    #1;
    check("reset_gnt", bus.gnt, 4'b0000);
    check("reset_sel", {2'b00, bus.s1, bus.s0}, 4'b0000);
    check("reset_enable", {3'b000, bus.enable}, 4'b0000);
    check("reset_busy", {3'b000, bus.busy}, 4'b0000);
    @(negedge clk);
    reset = 1'b0;

    // Single request and release; select lines keep their value in IDLE.
    bus.req = 4'b0100;
    @(negedge clk);
    check("single_gnt", bus.gnt, 4'b0100);
    check("single_sel", {2'b00, bus.s1, bus.s0}, 4'b0010);
    check("single_enable", {3'b000, bus.enable}, 4'b0001);
    bus.req = 4'b0000;
    @(negedge clk);
    check("release_gnt", bus.gnt, 4'b0000);
    check("release_enable", {3'b000, bus.enable}, 4'b0000);
    check("release_sel", {2'b00, bus.s1, bus.s0}, 4'b0010);

    // Handoff from holder 1 straight to 3 with no idle cycle.
    bus.req = 4'b0010;
    @(negedge clk);
    check("handoff_first", bus.gnt, 4'b0010);
    bus.req = 4'b1000;
    @(negedge clk);
    check("handoff_gnt", bus.gnt, 4'b1000);
    check("handoff_sel", {2'b00, bus.s1, bus.s0}, 4'b0011);
    check("handoff_enable", {3'b000, bus.enable}, 4'b0001);
    bus.req = 4'b0000;
    @(negedge clk);

    // Round robin with all requesting; each holder drops for one cycle after two granted cycles.
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp = 4'b0001 << (i % 4);
      @(negedge clk);
      check("rr_gnt_c1", bus.gnt, exp);
      bus.req = 4'b1111;
      @(negedge clk);
      check("rr_gnt_c2", bus.gnt, exp);
      bus.req = 4'b1111 & ~exp;
    end
    bus.req = 4'b0000;
    @(negedge clk);

    // Asynchronous reset mid-grant, then fresh arbitration starts at 0.
    bus.req = 4'b0100;
    @(negedge clk);
    check("midgrant_gnt", bus.gnt, 4'b0100);
    #2 reset = 1'b1;
    #1;
    check("async_rst_gnt", bus.gnt, 4'b0000);
    check("async_rst_enable", {3'b000, bus.enable}, 4'b0000);
    check("async_rst_sel", {2'b00, bus.s1, bus.s0}, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    bus.req = 4'b1111;
    @(negedge clk);
    check("post_rst_gnt", bus.gnt, 4'b0001);
    bus.req = 4'b0000;
    @(negedge clk);

    // Two constant requesters: timeout alternation, or permanent hold without the feature.
    pulse_reset();
    bus.req = 4'b0011;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
`ifdef MUX4_ARB_TIMEOUT_EN
      exp = ((c / 4) % 2 == 0) ? 4'b0001 : 4'b0010;
`else
      exp = 4'b0001;
`endif
      check("timeout_gnt", bus.gnt, exp);
    end
    bus.req = 4'b0000;
    @(negedge clk);

    // Saturated hold counter: a late competing request rotates on the next edge.
    pulse_reset();
    bus.req = 4'b0001;
    repeat (10) @(negedge clk);
    check("sat_hold_gnt", bus.gnt, 4'b0001);
    bus.req = 4'b0101;
    @(negedge clk);
`ifdef MUX4_ARB_TIMEOUT_EN
    check("sat_rotate_gnt", bus.gnt, 4'b0100);
`else
    check("sat_rotate_gnt", bus.gnt, 4'b0001);
`endif
    bus.req = 4'b0000;
    @(negedge clk);

    // Random traffic with sticky requests so grants are held for varying lengths.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) < 3) bus.req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
